// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and payload builders for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef logic [31:0] u32;
  typedef logic [3:0]  u4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_t;

  typedef struct packed {
    logic write;
    u32   addr;
    u32   wdata;
    u4    strobe;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_IDLE = '0;

  function automatic mem_req_t fetch_req(input u32 addr);
    mem_req_t r;
    r      = MEM_REQ_IDLE;
    r.addr = addr;
    return r;
  endfunction

  // Byte enables only mean something for a store; loads always present 4'h0.
  function automatic mem_req_t data_req(input logic write, input u32 addr,
                                        input u32 wdata, input u4 strobe);
    mem_req_t r;
    r.write  = write;
    r.addr   = addr;
    r.wdata  = wdata;
    r.strobe = write ? strobe : 4'h0;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DSTREAK = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic ireq_valid,
  input  u32   ireq_addr,
  output logic iresp_valid,
  output u32   iresp_data,
  input  logic dreq_valid,
  input  logic dreq_write,
  input  u32   dreq_addr,
  input  u32   dreq_wdata,
  input  u4    dreq_strobe,
  output logic dresp_valid,
  output u32   dresp_data,
  output logic mem_req,
  output logic mem_write,
  output u32   mem_addr,
  output u32   mem_wdata,
  output u4    mem_strobe,
  input  logic mem_ready,
  input  u32   mem_rdata,
  output logic stall_fetch,
  output logic stall_mem
);

  localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  mem_req_t            req_q, req_d;
  logic                mem_req_q, mem_req_d;
  logic                iresp_valid_q, iresp_valid_d;
  logic                dresp_valid_q, dresp_valid_d;
  u32                  iresp_data_q, iresp_data_d;
  u32                  dresp_data_q, dresp_data_d;
  logic                i_elig, d_elig, fetch_turn;

  // A requester may still hold valid during its own response cycle, so it sits that cycle out.
  assign i_elig     = ireq_valid & ~iresp_valid_q;
  assign d_elig     = dreq_valid & ~dresp_valid_q;
  assign fetch_turn = i_elig && (streak_q == STREAK_MAX);

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    req_d         = req_q;
    mem_req_d     = mem_req_q;
    iresp_valid_d = 1'b0;
    dresp_valid_d = 1'b0;
    iresp_data_d  = iresp_data_q;
    dresp_data_d  = dresp_data_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (d_elig && !fetch_turn) begin
          state_d   = ARB_BUSY_D;
          req_d     = data_req(dreq_write, dreq_addr, dreq_wdata, dreq_strobe);
          mem_req_d = 1'b1;
          if (i_elig && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (i_elig) begin
          state_d   = ARB_BUSY_I;
          req_d     = fetch_req(ireq_addr);
          mem_req_d = 1'b1;
          streak_d  = '0;
        end
      end
      ARB_BUSY_I: begin
        if (mem_ready) begin
          state_d       = ARB_IDLE;
          mem_req_d     = 1'b0;
          iresp_valid_d = 1'b1;
          iresp_data_d  = mem_rdata;
        end
      end
      ARB_BUSY_D: begin
        if (mem_ready) begin
          state_d       = ARB_IDLE;
          mem_req_d     = 1'b0;
          dresp_valid_d = 1'b1;
          dresp_data_d  = req_q.write ? '0 : mem_rdata;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ARB_IDLE;
      streak_q      <= '0;
      req_q         <= MEM_REQ_IDLE;
      mem_req_q     <= 1'b0;
      iresp_valid_q <= 1'b0;
      dresp_valid_q <= 1'b0;
      iresp_data_q  <= '0;
      dresp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      req_q         <= req_d;
      mem_req_q     <= mem_req_d;
      iresp_valid_q <= iresp_valid_d;
      dresp_valid_q <= dresp_valid_d;
      iresp_data_q  <= iresp_data_d;
      dresp_data_q  <= dresp_data_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_write   = req_q.write;
  assign mem_addr    = req_q.addr;
  assign mem_wdata   = req_q.wdata;
  assign mem_strobe  = req_q.strobe;
  assign iresp_valid = iresp_valid_q;
  assign iresp_data  = iresp_data_q;
  assign dresp_valid = dresp_valid_q;
  assign dresp_data  = dresp_data_q;

  assign stall_fetch = ireq_valid & ~iresp_valid_q;
  assign stall_mem   = dreq_valid & ~dresp_valid_q;

  // Withdrawing a request mid-access is a requester bug; the access still runs to completion.
  a_ireq_held: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == ARB_BUSY_I) |-> ireq_valid);
  a_dreq_held: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == ARB_BUSY_D) |-> dreq_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXD = 2;

  logic clk = 1'b0;
  logic resetn;
  logic ireq_valid, iresp_valid;
  u32   ireq_addr, iresp_data;
  logic dreq_valid, dreq_write, dresp_valid;
  u32   dreq_addr, dreq_wdata, dresp_data;
  u4    dreq_strobe;
  logic mem_req, mem_write, mem_ready;
  u32   mem_addr, mem_wdata, mem_rdata;
  u4    mem_strobe;
  logic stall_fetch, stall_mem;

  mem_port_arbiter #(.MAX_DSTREAK(MAXD)) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_wdata(dreq_wdata), .dreq_strobe(dreq_strobe),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strobe(mem_strobe),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscompares = 0;

  // reference model: owner 0 = port free, 1 = fetch, 2 = data
  int   m_owner, m_streak;
  logic m_req, m_write, m_iresp, m_dresp;
  u32   m_addr, m_wdata, m_idata, m_ddata;
  u4    m_strobe;
  u32   m_gaddr[$];

  // what the DUT actually put on the port / returned
  u32   obs_addr[$], obs_wdata[$], obs_ddata[$];
  logic obs_write[$];
  u4    obs_strobe[$];
  logic prev_req;
  int   resp_cnt;

  // requester and memory agents
  bit   hold_rst, i_active, d_active, ready_noise, ready_tied, rdata_fix;
  int   i_prob, d_prob, lat_min, lat_max, lat_left;
  u32   i_addr_cur, d_addr_cur, d_wdata_cur, rdata_val;
  logic d_write_cur;
  u4    d_strobe_cur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_streak = 0; m_req = 0; m_write = 0; m_iresp = 0; m_dresp = 0;
    m_addr = '0; m_wdata = '0; m_idata = '0; m_ddata = '0; m_strobe = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    bit ie, de;
    if (!resetn) begin
      model_reset();
      return;
    end
    ie = ireq_valid && !m_iresp;
    de = dreq_valid && !m_dresp;
    if (m_owner != 0) begin
      if (mem_ready) begin
        if (m_owner == 1) begin m_iresp = 1; m_idata = mem_rdata; end
        else begin m_dresp = 1; m_ddata = m_write ? 32'h0 : mem_rdata; end
        m_owner = 0;
        m_req = 0;
      end
    end else begin
      m_iresp = 0;
      m_dresp = 0;
      if (de && !(ie && m_streak == MAXD)) begin
        m_owner = 2; m_req = 1; m_write = dreq_write; m_addr = dreq_addr;
        m_wdata = dreq_wdata; m_strobe = dreq_write ? dreq_strobe : 4'h0;
        if (ie) m_streak = (m_streak + 1 > MAXD) ? MAXD : m_streak + 1;
        m_gaddr.push_back(dreq_addr);
      end else if (ie) begin
        m_owner = 1; m_req = 1; m_write = 0; m_addr = ireq_addr;
        m_wdata = '0; m_strobe = 4'h0; m_streak = 0;
        m_gaddr.push_back(ireq_addr);
      end
    end
  endtask

  task automatic compare();
    check_eq("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req) begin
      check_eq("mem_addr", mem_addr, m_addr);
      check_eq("mem_write", 32'(mem_write), 32'(m_write));
      check_eq("mem_strobe", 32'(mem_strobe), 32'(m_strobe));
      if (m_write) check_eq("mem_wdata", mem_wdata, m_wdata);
    end
    check_eq("iresp_valid", 32'(iresp_valid), 32'(m_iresp));
    if (m_iresp) check_eq("iresp_data", iresp_data, m_idata);
    check_eq("dresp_valid", 32'(dresp_valid), 32'(m_dresp));
    if (m_dresp) check_eq("dresp_data", dresp_data, m_ddata);
    check_eq("streak", 32'(dut.streak_q), 32'(m_streak));
    check_eq("stall_fetch_hold", 32'(stall_fetch), 32'(ireq_valid && !m_iresp));
    if (mem_req && !prev_req) begin
      obs_addr.push_back(mem_addr); obs_write.push_back(mem_write);
      obs_wdata.push_back(mem_wdata); obs_strobe.push_back(mem_strobe);
    end
    prev_req = mem_req;
    if (dresp_valid) obs_ddata.push_back(dresp_data);
    if (iresp_valid || dresp_valid) resp_cnt++;
  endtask

  task automatic drive();
    resetn = !hold_rst;
    if (m_iresp) i_active = 0;
    if (m_dresp) d_active = 0;
    if (!i_active && int'($urandom_range(99)) < i_prob) begin
      i_active = 1;
      i_addr_cur = {8'hBF, 22'($urandom()), 2'b00};
    end
    if (!d_active && int'($urandom_range(99)) < d_prob) begin
      d_active = 1;
      d_write_cur = 1'($urandom_range(1));
      d_addr_cur = {4'h8, 26'($urandom()), 2'b00};
      d_wdata_cur = $urandom();
      d_strobe_cur = 4'($urandom_range(15, 1));
    end
    ireq_valid = i_active; ireq_addr = i_addr_cur;
    dreq_valid = d_active; dreq_write = d_write_cur; dreq_addr = d_addr_cur;
    dreq_wdata = d_wdata_cur; dreq_strobe = d_strobe_cur;
    mem_rdata = rdata_fix ? rdata_val : $urandom();
    if (ready_tied) begin
      mem_ready = 1; lat_left = -1;
    end else if (m_req) begin
      if (lat_left < 0) lat_left = int'($urandom_range(lat_max, lat_min));
      mem_ready = (lat_left == 0);
      lat_left--;
      if (mem_ready) lat_left = -1;
    end else begin
      mem_ready = ready_noise && ($urandom_range(3) == 0);
      lat_left = -1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    drive();
    #1;
    check_eq("stall_fetch", 32'(stall_fetch), 32'(ireq_valid && !m_iresp));
    check_eq("stall_mem", 32'(stall_mem), 32'(dreq_valid && !m_dresp));
    model_step();
  endtask

  task automatic drain();
    int n = 0;
    i_prob = 0; d_prob = 0; ready_tied = 0;
    while ((i_active || d_active || m_owner != 0 || m_iresp || m_dresp) && n < 200) begin
      cycle(); n++;
    end
    check_eq("drain_idle", 32'(i_active || d_active || m_owner != 0), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g0, g1;
    resetn = 0; hold_rst = 1;
    ireq_valid = 0; ireq_addr = '0; dreq_valid = 0; dreq_write = 0; dreq_addr = '0;
    dreq_wdata = '0; dreq_strobe = '0; mem_ready = 0; mem_rdata = '0;
    i_active = 0; d_active = 0; i_prob = 0; d_prob = 0; ready_noise = 0; ready_tied = 0;
    rdata_fix = 0; rdata_val = '0; lat_min = 0; lat_max = 2; lat_left = -1;
    i_addr_cur = '0; d_addr_cur = '0; d_wdata_cur = '0; d_write_cur = 0; d_strobe_cur = '0;
    prev_req = 0; resp_cnt = 0;
    model_reset();
    repeat (3) cycle();
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_mem_strobe", 32'(mem_strobe), 32'h0);
    check_eq("rst_mem_write", 32'(mem_write), 32'h0);
    check_eq("rst_resp_data", iresp_data | dresp_data, 32'h0);
    hold_rst = 0;
    cycle();

    // fetch only, memory answers on the third request cycle
    drain();
    rdata_fix = 1; rdata_val = 32'h2008_0005; lat_min = 2; lat_max = 2;
    i_active = 1; i_addr_cur = 32'hBFC0_0000;
    n = 0;
    do begin cycle(); n++; end while (!m_iresp && n < 20);
    check_eq("t1_latency", 32'(n), 32'd4);
    cycle();
    check_eq("t1_idata", iresp_data, 32'h2008_0005);

    // simultaneous fetch and load: data goes first
    drain();
    rdata_fix = 0; lat_min = 0; lat_max = 2;
    g0 = obs_addr.size();
    i_active = 1; i_addr_cur = 32'hBFC0_0100;
    d_active = 1; d_write_cur = 0; d_addr_cur = 32'h8000_0040; d_wdata_cur = $urandom(); d_strobe_cur = 4'h3;
    drain();
    check_eq("t2_grants", 32'(obs_addr.size() >= g0 + 2), 32'h1);
    if (obs_addr.size() >= g0 + 2) begin
      check_eq("t2_first_addr", obs_addr[g0], 32'h8000_0040);
      check_eq("t2_second_addr", obs_addr[g0+1], 32'hBFC0_0100);
    end

    // data continuously re-raised with fetch held
    drain();
    i_prob = 100; d_prob = 100;
    g0 = m_gaddr.size(); n = 0;
    while (m_gaddr.size() < g0 + 6 && n < 200) begin cycle(); n++; end
    cycle();
    check_eq("t3_obs_count", 32'(obs_addr.size() >= g0 + 6), 32'h1);
    for (int k = g0; k < g0 + 6; k++)
      if (k < obs_addr.size()) check_eq("t3_order", obs_addr[k], m_gaddr[k]);

    // store: strobes and write data on the port, zero returned
    drain();
    rdata_fix = 1; rdata_val = 32'hFFFF_FFFF;
    g0 = obs_addr.size(); g1 = obs_ddata.size();
    d_active = 1; d_write_cur = 1; d_addr_cur = 32'h8000_0010;
    d_wdata_cur = 32'hDEAD_BEEF; d_strobe_cur = 4'hF;
    drain();
    if (obs_addr.size() > g0 && obs_ddata.size() > g1) begin
      check_eq("t4_addr", obs_addr[g0], 32'h8000_0010);
      check_eq("t4_write", 32'(obs_write[g0]), 32'h1);
      check_eq("t4_strobe", 32'(obs_strobe[g0]), 32'hF);
      check_eq("t4_wdata", obs_wdata[g0], 32'hDEAD_BEEF);
      check_eq("t4_dresp_data", obs_ddata[g1], 32'h0);
    end else check_eq("t4_seen", 32'(obs_ddata.size()), 32'(g1 + 1));

    // reset in the middle of a data access
    drain();
    rdata_fix = 0; lat_min = 6; lat_max = 6;
    d_active = 1; d_write_cur = 0; d_addr_cur = 32'h8000_0080; d_wdata_cur = '0; d_strobe_cur = 4'h1;
    n = 0;
    while (m_owner != 2 && n < 20) begin cycle(); n++; end
    cycle(); cycle();
    g1 = obs_ddata.size();
    @(negedge clk);
    compare();
    hold_rst = 1; resetn = 0; mem_ready = 0;
    d_active = 0; dreq_valid = 0;
    i_active = 1; i_addr_cur = 32'hBFC0_0200; ireq_valid = 1; ireq_addr = 32'hBFC0_0200;
    #1;
    check_eq("t5_mem_req_async", 32'(mem_req), 32'h0);
    check_eq("t5_no_dresp", 32'(dresp_valid), 32'h0);
    model_reset(); lat_left = -1; lat_min = 0; lat_max = 1;
    cycle(); cycle();
    hold_rst = 0;
    g0 = obs_addr.size(); n = 0;
    while (!m_iresp && n < 20) begin cycle(); n++; end
    cycle();
    check_eq("t5_fetch_after_reset", 32'(obs_addr.size() > g0), 32'h1);
    if (obs_addr.size() > g0) check_eq("t5_fetch_addr", obs_addr[g0], 32'hBFC0_0200);
    check_eq("t5_dresp_suppressed", 32'(obs_ddata.size()), 32'(g1));

    // ready tied high, both always requesting: one response every two cycles
    drain();
    ready_tied = 1; i_prob = 100; d_prob = 100;
    repeat (4) cycle();
    resp_cnt = 0;
    repeat (40) cycle();
    check_eq("t6_resp_count", 32'(resp_cnt), 32'd20);

    // random traffic, latencies and stray mem_ready pulses
    drain();
    for (int blk = 0; blk < 15; blk++) begin
      i_prob = int'($urandom_range(100));
      d_prob = int'($urandom_range(100));
      lat_min = 0;
      lat_max = int'($urandom_range(4));
      ready_noise = 1'($urandom_range(1));
      rdata_fix = 0;
      repeat (100) cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
